// File: rtl/imm_gen_queue.sv
// imm_gen_queue: registered RV32I/RV64I immediate decoder feeding a DEPTH-entry FIFO.
// Instruction words enter over a valid/ready handshake and are decoded into
// immediate, format and illegal flag as they are written. The head entry is
// presented downstream over a second valid/ready handshake.
// Optional feature: define IMM_ILLEGAL_COUNT_EN to add illegal_count_o, a
// saturating count of pushed entries with an unrecognised opcode.
module imm_gen_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  flush_i,
    input  logic [31:0]           ir_i,
    input  logic                  ir_valid_i,
    output logic                  ir_ready_o,
    output logic [DATA_WIDTH-1:0] imm_o,
    output logic [2:0]            imm_type_o,
    output logic                  illegal_o,
    output logic                  imm_valid_o,
    input  logic                  imm_ready_i
`ifdef IMM_ILLEGAL_COUNT_EN
    ,
    output logic [7:0]            illegal_count_o
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [2:0] FMT_I     = 3'd0;
    localparam logic [2:0] FMT_S     = 3'd1;
    localparam logic [2:0] FMT_B     = 3'd2;
    localparam logic [2:0] FMT_U     = 3'd3;
    localparam logic [2:0] FMT_J     = 3'd4;
    localparam logic [2:0] FMT_SHAMT = 3'd5;
    localparam logic [2:0] FMT_NONE  = 3'd7;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] imm;
        logic [2:0]            fmt;
        logic                  illegal;
    } entry_t;

    entry_t             mem [DEPTH];
    entry_t             last_q;
    entry_t             dec;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   cnt;
    logic [63:0]        imm64;
    logic               push, pop;

    wire [6:0] opcode = ir_i[6:0];
    wire [2:0] f3     = ir_i[14:12];
    wire       s      = ir_i[31];

    assign ir_ready_o  = (cnt < CNT_W'(DEPTH));
    assign imm_valid_o = (cnt != '0);
    assign push        = ir_valid_i && ir_ready_o && !flush_i;
    assign pop         = imm_valid_o && imm_ready_i && !flush_i;

    // Head entry while non-empty; otherwise the last popped (or reset) entry.
    assign imm_o      = imm_valid_o ? mem[rd_ptr].imm     : last_q.imm;
    assign imm_type_o = imm_valid_o ? mem[rd_ptr].fmt     : last_q.fmt;
    assign illegal_o  = imm_valid_o ? mem[rd_ptr].illegal : last_q.illegal;

    // Decode immediate and format; built at 64 bits then truncated so RV32 and RV64 share one path.
    always_comb begin
        imm64       = '0;
        dec.fmt     = FMT_NONE;
        dec.illegal = 1'b0;
        case (opcode)
            7'b0010011: begin
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    dec.fmt = FMT_SHAMT;
                    if (DATA_WIDTH == 64) imm64 = {58'b0, ir_i[25:20]};
                    else                  imm64 = {59'b0, ir_i[24:20]};
                end else begin
                    dec.fmt = FMT_I;
                    imm64   = {{52{s}}, ir_i[31:20]};
                end
            end
            7'b0000011, 7'b1100111, 7'b1110011: begin
                dec.fmt = FMT_I;
                imm64   = {{52{s}}, ir_i[31:20]};
            end
            7'b0100011: begin
                dec.fmt = FMT_S;
                imm64   = {{52{s}}, ir_i[31:25], ir_i[11:7]};
            end
            7'b1100011: begin
                dec.fmt = FMT_B;
                imm64   = {{51{s}}, ir_i[31], ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec.fmt = FMT_U;
                imm64   = {{32{s}}, ir_i[31:12], 12'b0};
            end
            7'b1101111: begin
                dec.fmt = FMT_J;
                imm64   = {{43{s}}, ir_i[31], ir_i[19:12], ir_i[20], ir_i[30:21], 1'b0};
            end
            default: begin
                dec.fmt     = FMT_NONE;
                dec.illegal = 1'b1;
            end
        endcase
        dec.imm = imm64[DATA_WIDTH-1:0];
    end

    // FIFO storage, pointers and occupancy; reset clears storage, flush only empties the queue.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            last_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush_i) begin
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= dec;
                wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                last_q <= mem[rd_ptr];
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (push && !pop)      cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;
        end
    end

`ifdef IMM_ILLEGAL_COUNT_EN
    logic [7:0] ill_cnt;
    assign illegal_count_o = ill_cnt;

    // Saturating count of accepted illegal words; survives flush.
    always_ff @(posedge clk_i) begin
        if (!reset_ni)                                    ill_cnt <= '0;
        else if (push && dec.illegal && ill_cnt != 8'hFF) ill_cnt <= ill_cnt + 1'b1;
    end
`endif

endmodule
